aes_byte_sequencer: RTL and testbench
=====================================

AES_BYTE_SEQUENCER -- requirements
Module: aes_byte_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, sets the clock cycles allowed for the external combinational AES core to settle (legal range 1..15).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 ena  in  1  global enable; when 0 all state, counters and registers hold.
REQ-005 in_valid  in  1  in_byte is offered this cycle.
REQ-006 in_byte  in  8  loaded byte, MSB-first order.
REQ-007 in_sel  in  1  target of in_byte: 0 = text register, 1 = key register.
REQ-008 mode  in  1  operation, sampled at start: 0 = encrypt, 1 = decrypt.
REQ-009 start  in  1  single-cycle request to run the core.
REQ-010 out_ready  in  1  consumer accepts out_byte.
REQ-011 core_result  in  128  output of the selected external AES core.
REQ-012 in_ready  out  1  byte load is accepted this cycle.
REQ-013 out_valid  out  1  out_byte holds a valid result byte.
REQ-014 out_byte  out  8  current result byte, MSB first.
REQ-015 busy  out  1  high in RUN and OUT.
REQ-016 done  out  1  one-cycle pulse after the last result byte is accepted.
REQ-017 err  out  1  one-cycle pulse when start is rejected.
REQ-018 core_text, core_key  out  128 each  registered operands driven to the core.
REQ-019 core_mode  out  1  registered mode; selects the encrypt or decrypt core result.

Function
REQ-020 The FSM states SHALL be IDLE, RUN and OUT; ena = 0 blocks every transition and register update.
REQ-021 In IDLE, in_ready SHALL be 1; in RUN and OUT it SHALL be 0.
REQ-022 An accepted byte (in_valid & in_ready) SHALL update the selected register as reg <= {reg[119:0], in_byte} and increment its 5-bit count.
REQ-023 Counts SHALL saturate at 16; further bytes still shift, so the last 16 bytes win.
REQ-024 In IDLE, start with text_cnt = 16 and key_cnt = 16 SHALL latch mode into core_mode, clear the settle counter and enter RUN.
REQ-025 In IDLE, start with either count < 16 SHALL pulse err for one cycle and remain in IDLE.
REQ-026 start in RUN or OUT SHALL be ignored, with no err pulse.
REQ-027 If start and an accepted byte coincide in IDLE, the byte SHALL be loaded and the start check SHALL use the pre-update counts.
REQ-028 RUN SHALL last exactly SETTLE_CYCLES cycles; on the last cycle core_result SHALL be captured into the 128-bit result register and the FSM SHALL enter OUT.
REQ-029 core_text, core_key and core_mode SHALL stay stable throughout RUN.
REQ-030 In OUT, out_valid = 1 and out_byte = result[127:120].
REQ-031 Each out_valid & out_ready handshake SHALL shift result left 8 bits and increment a 4-bit byte counter.
REQ-032 On the 16th handshake the FSM SHALL enter IDLE, pulse done for one cycle, clear text_cnt to 0 and retain the key (key_cnt stays 16).
REQ-033 out_valid SHALL hold while out_ready = 0; back-to-back handshakes SHALL deliver one byte per cycle.
REQ-034 Latency from start acceptance to the first out_valid SHALL be SETTLE_CYCLES + 1 cycles.
REQ-035 When outputs are not in use they SHALL be 0: out_byte = 0 when out_valid = 0.

Reset
REQ-036 rst_n = 0 SHALL immediately force IDLE, clear both counts, the settle and byte counters, and all data registers, and drive in_ready=1, out_valid=0, out_byte=0, busy=0, done=0, err=0, core_mode=0.
REQ-037 Reset asserted mid-RUN or mid-OUT SHALL abort the operation with no done pulse.
REQ-038 After reset deassertion, a new 32-byte load SHALL be required before start is accepted.

Verification (bench connects the team's combinational AES encrypt/decrypt cores to core_*)
REQ-039 Load key 000102..0f and text 00112233..eeff, start with mode=0, out_ready=1 -> out_valid after 5 cycles, then bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a, then a done pulse.
REQ-040 With the key retained, load text 69c4..c55a, start with mode=1 -> output 00 11 22 .. ff, no err.
REQ-041 start after only 15 text bytes -> err pulse, state stays IDLE, busy=0.
REQ-042 out_ready toggled randomly in OUT -> each byte held until accepted, the 16-byte sequence is unchanged, and in_ready=0 until done.
REQ-043 rst_n pulsed low in cycle 2 of RUN -> all outputs at reset values asynchronously, no done, and a subsequent start gives err.
REQ-044 ena=0 for 3 cycles mid-OUT -> out_byte, counters and state frozen, and the sequence resumes intact.

Source files
------------

// File: rtl/aes_byte_sequencer.sv
// Byte-serial load/unload wrapper around an external combinational AES core.
// Shifts operands in, waits for the core to settle, then streams the result.
module aes_byte_sequencer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         in_valid,
  input  logic [7:0]   in_byte,
  input  logic         in_sel,
  input  logic         mode,
  input  logic         start,
  input  logic         out_ready,
  input  logic [127:0] core_result,
  output logic         in_ready,
  output logic         out_valid,
  output logic [7:0]   out_byte,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [127:0] core_text,
  output logic [127:0] core_key,
  output logic         core_mode
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    OUT
  } state_t;

  state_t state_q, state_d;

  logic [127:0] text_q, key_q, res_q;
  logic [4:0]   text_cnt, key_cnt;
  logic [3:0]   settle_cnt, byte_cnt;
  logic         mode_q, done_q, err_q;
  logic         load, full, settle_last, hs;

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == OUT);
  assign busy        = (state_q != IDLE);
  assign out_byte    = out_valid ? res_q[127:120] : 8'h00;
  assign done        = done_q;
  assign err         = err_q;
  assign core_text   = text_q;
  assign core_key    = key_q;
  assign core_mode   = mode_q;

  assign load        = in_valid & in_ready & ena;
  assign full        = (text_cnt == 5'd16) && (key_cnt == 5'd16);
  assign settle_last = (settle_cnt == 4'(SETTLE_CYCLES - 1));
  assign hs          = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start && full) state_d = RUN;
      RUN:  if (settle_last) state_d = OUT;
      OUT:  if (hs && byte_cnt == 4'd15) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      text_q     <= '0;
      key_q      <= '0;
      res_q      <= '0;
      text_cnt   <= '0;
      key_cnt    <= '0;
      settle_cnt <= '0;
      byte_cnt   <= '0;
      mode_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      // counts saturate but the shift keeps going: last 16 bytes win
      if (load) begin
        if (in_sel) begin
          key_q <= {key_q[119:0], in_byte};
          if (key_cnt != 5'd16) key_cnt <= key_cnt + 5'd1;
        end else begin
          text_q <= {text_q[119:0], in_byte};
          if (text_cnt != 5'd16) text_cnt <= text_cnt + 5'd1;
        end
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (full) begin
              mode_q     <= mode;
              settle_cnt <= '0;
              byte_cnt   <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          settle_cnt <= settle_cnt + 4'd1;
          if (settle_last) res_q <= core_result;
        end
        OUT: begin
          if (hs) begin
            res_q    <= {res_q[119:0], 8'h00};
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == 4'd15) begin
              done_q   <= 1'b1;
              text_cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_byte_sequencer.sv
// Scoreboard bench for aes_byte_sequencer with a behavioural AES core
// and a byte-level reference model of the load/start/unload rules.
module tb_aes_byte_sequencer;

  localparam int S = 4;

  logic         clk, rst_n, ena;
  logic         in_valid, in_sel, mode, start, out_ready;
  logic [7:0]   in_byte;
  logic [127:0] core_result;
  logic         in_ready, out_valid, busy, done, err;
  logic [7:0]   out_byte;
  logic [127:0] core_text, core_key;
  logic         core_mode;

  aes_byte_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(in_valid), .in_byte(in_byte),
    .in_sel(in_sel), .mode(mode), .start(start),
    .out_ready(out_ready), .core_result(core_result),
    .in_ready(in_ready), .out_valid(out_valid),
    .out_byte(out_byte), .busy(busy), .done(done),
    .err(err), .core_text(core_text),
    .core_key(core_key), .core_mode(core_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural AES ----------------
  logic [7:0] sb[256];
  logic [7:0] isb[256];
  bit tables_ready = 0;

  function automatic logic [7:0] xt(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol(logic [7:0] b, int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rol(inv, 1) ^ rol(inv, 2)
            ^ rol(inv, 3) ^ rol(inv, 4) ^ 8'h63;
      isb[sb[x]] = 8'(x);
    end
    tables_ready = 1;
  end

  function automatic logic [10:0][127:0] expand(logic [127:0] k);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    logic [10:0][127:0] rk;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]}
          ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  function automatic logic [127:0] sub_b(logic [127:0] s, bit inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? isb[s[127-8*i -: 8]] : sb[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_r(logic [127:0] s, bit inv);
    logic [127:0] o;
    int src;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*src) -: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix_c(logic [127:0] s, bit inv);
    logic [127:0] o;
    logic [7:0] cf[4];
    logic [7:0] a[4];
    logic [7:0] v;
    if (inv) cf = '{8'd14, 8'd11, 8'd13, 8'd9};
    else     cf = '{8'd2, 8'd3, 8'd1, 8'd1};
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127-8*(4*c+j) -: 8];
      for (int k = 0; k < 4; k++) begin
        v = 0;
        for (int j = 0; j < 4; j++) v = v ^ gmul(cf[(j-k+4)%4], a[j]);
        o[127-8*(4*c+k) -: 8] = v;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_enc(logic [127:0] p, logic [127:0] k);
    logic [10:0][127:0] rk = expand(k);
    logic [127:0] s = p ^ rk[0];
    for (int r = 1; r <= 10; r++) begin
      s = shift_r(sub_b(s, 0), 0);
      if (r < 10) s = mix_c(s, 0);
      s = s ^ rk[r];
    end
    return s;
  endfunction

  function automatic logic [127:0] aes_dec(logic [127:0] c, logic [127:0] k);
    logic [10:0][127:0] rk = expand(k);
    logic [127:0] s = c ^ rk[10];
    for (int r = 9; r >= 0; r--) begin
      s = sub_b(shift_r(s, 1), 1) ^ rk[r];
      if (r > 0) s = mix_c(s, 1);
    end
    return s;
  endfunction

  always @(core_text or core_key or core_mode or tables_ready)
    if (!tables_ready) core_result = '0;
    else if (core_mode) core_result = aes_dec(core_text, core_key);
    else core_result = aes_enc(core_text, core_key);

  // ---------------- reference model ----------------
  logic [7:0] m_text[$];
  logic [7:0] m_key[$];
  int m_tcnt, m_kcnt;
  logic [7:0] exp_q[$];

  function automatic logic [127:0] pack(logic [7:0] q[$]);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = q[i];
    return v;
  endfunction

  task automatic m_reset();
    m_text.delete(); m_key.delete();
    repeat (16) begin m_text.push_back(0); m_key.push_back(0); end
    m_tcnt = 0; m_kcnt = 0;
    exp_q.delete();
  endtask

  task automatic m_push(input bit sel, input logic [7:0] b);
    if (sel) begin
      void'(m_key.pop_front()); m_key.push_back(b);
      if (m_kcnt < 16) m_kcnt++;
    end else begin
      void'(m_text.pop_front()); m_text.push_back(b);
      if (m_tcnt < 16) m_tcnt++;
    end
  endtask

  // ---------------- monitor ----------------
  bit rdy_rand = 0;
  int done_cnt = 0;
  int done_base = 0;
  logic pend = 0;
  logic [7:0] pbyte;

  initial forever begin
    @(negedge clk);
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial forever begin
    @(negedge clk); #4;
    if (!rst_n) pend = 0;
    else begin
      if (pend) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_byte", out_byte, pbyte);
      end
      if (!out_valid) chk("idle_byte_zero", out_byte, 0);
      chk("in_ready_vs_busy", in_ready, !busy);
      if (done && ena) done_cnt++;
      if (out_valid && out_ready && ena) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte: got %h expected none", out_byte);
        end else chk("out_byte", out_byte, exp_q.pop_front());
      end
      pend = out_valid && !(out_ready && ena);
      pbyte = out_byte;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic load_byte(input bit sel, input logic [7:0] b);
    @(negedge clk);
    in_valid = 1; in_sel = sel; in_byte = b;
    #4 chk("load_in_ready", in_ready, 1);
    @(posedge clk);
    m_push(sel, b);
    #1 in_valid = 0;
  endtask

  task automatic load16(input bit sel, input logic [127:0] v);
    for (int i = 0; i < 16; i++) load_byte(sel, v[127-8*i -: 8]);
  endtask

  task automatic do_start(input bit md, input bit use_f,
                          input logic [127:0] fv);
    bit ok = (m_tcnt == 16) && (m_kcnt == 16);
    logic [127:0] r;
    if (use_f) r = fv;
    else if (md) r = aes_dec(pack(m_text), pack(m_key));
    else r = aes_enc(pack(m_text), pack(m_key));
    done_base = done_cnt;
    @(negedge clk);
    start = 1; mode = md;
    @(posedge clk);
    if (ok) for (int i = 0; i < 16; i++) exp_q.push_back(r[127-8*i -: 8]);
    #1 start = 0;
    chk("start_err", err, !ok);
    chk("start_busy", busy, ok);
    if (!ok) begin
      @(posedge clk); #1;
      chk("err_one_cycle", err, 0);
    end
  endtask

  task automatic wait_first();
    int lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, S + 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == done_base && n < 1000) begin
      @(posedge clk); n++;
    end
    chk("done_pulse", done_cnt, done_base + 1);
    chk("drained", exp_q.size(), 0);
    m_tcnt = 0;
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    logic [7:0] fb;
    rst_n = 0; ena = 1; in_valid = 0; in_sel = 0;
    in_byte = 0; mode = 0; start = 0; out_ready = 1;
    m_reset();
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_mode", core_mode, 0);
    chk("rst_core_text", core_text, 0);
    @(negedge clk); rst_n = 1;

    // known-answer encrypt then decrypt with retained key
    load16(1, KEY);
    load16(0, PT);
    do_start(0, 1, CT);
    wait_first();
    wait_done();
    load16(0, CT);
    do_start(1, 1, PT);
    wait_first();
    wait_done();

    // short text load is rejected
    for (int i = 0; i < 15; i++) load_byte(0, 8'($urandom));
    do_start(0, 0, '0);
    chk("short_busy", busy, 0);

    // start coinciding with the 16th byte checks the old count
    @(negedge clk);
    in_valid = 1; in_sel = 0; in_byte = 8'hA5; start = 1; mode = 0;
    @(posedge clk);
    m_push(0, 8'hA5);
    #1 start = 0; in_valid = 0;
    chk("coincide_err", err, 1);
    chk("coincide_busy", busy, 0);

    // random backpressure plus a 3-cycle freeze mid-OUT
    rdy_rand = 1;
    do_start(1, 0, '0);
    wait_first();
    repeat (4) @(posedge clk);
    @(negedge clk);
    ena = 0;
    #1 fb = out_byte;
    repeat (3) begin
      @(posedge clk); #1;
      chk("freeze_byte", out_byte, fb);
      chk("freeze_busy", busy, 1);
      chk("freeze_valid", out_valid, 1);
    end
    @(negedge clk); ena = 1;
    wait_done();
    rdy_rand = 0;

    // reset in the second RUN cycle aborts silently
    load16(0, 128'($urandom) << 64 | 128'($urandom));
    do_start(0, 0, '0);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_byte", out_byte, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err, 0);
    chk("abort_core_mode", core_mode, 0);
    chk("abort_core_key", core_key, 0);
    m_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    repeat (S + 20) @(posedge clk);
    chk("abort_no_done", done_cnt, done_base);
    do_start(0, 0, '0);

    // randomized operations against the model
    for (int it = 0; it < 8; it++) begin
      int nt = $urandom_range(12, 20);
      rdy_rand = bit'($urandom_range(0, 1));
      if (it == 0 || $urandom_range(0, 2) == 0)
        for (int i = 0; i < $urandom_range(16, 18); i++)
          load_byte(1, 8'($urandom));
      for (int i = 0; i < nt; i++) load_byte(0, 8'($urandom));
      if (m_tcnt == 16 && m_kcnt == 16) begin
        do_start(bit'($urandom_range(0, 1)), 0, '0);
        wait_first();
        wait_done();
      end else do_start(0, 0, '0);
    end
    rdy_rand = 0;
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
